// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int N_REQ_DEF     = 4;
    localparam int DW_DEF        = 32;
    localparam int BURST_MAX_DEF = 4;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the write arbiter.
// The slave modport is the arbiter's view, the master modport the environment's.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_last;
    logic [N_REQ-1:0]    ack;
    logic                fifo_we;
    logic [DW-1:0]       fifo_din;
    logic                fifo_full;
    logic [IW-1:0]       gnt_id;
    logic                busy;

    modport master (
        output req, req_data, req_last, fifo_full,
        input  ack, fifo_we, fifo_din, gnt_id, busy
    );

    modport slave (
        input  req, req_data, req_last, fifo_full,
        output ack, fifo_we, fifo_din, gnt_id, busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: first requester with req high, starting one past last_gnt.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IW   = $clog2(N_REQ)
)(
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_gnt,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    logic [IW-1:0] cand;

    // Walk all positions after last_gnt (wrapping, ending on last_gnt itself) and keep the first hit.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(last_gnt) + k) % N_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst write arbiter: N requesters share one downstream sync FIFO.
// One IDLE cycle arbitrates, then the owner streams up to BURST_MAX words.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DW        = DW_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
)(
    input  logic             clk,
    input  logic             rst,
    fifo_wr_arbiter_if.slave bus
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(BURST_MAX + 1);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          in_burst;
    logic          accept;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req      (bus.req),
        .last_gnt (last_q),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    assign in_burst = (state_q == BURST);
    assign accept   = in_burst && bus.req[gnt_q] && !bus.fifo_full;
    assign cnt_inc  = cnt_q + CW'(1);

    // Zero-latency datapath: the owner's word goes straight to the FIFO; data is forced to zero outside a burst.
    always_comb begin
        bus.ack        = '0;
        bus.ack[gnt_q] = accept;
        bus.fifo_we    = accept;
        bus.fifo_din   = in_burst ? bus.req_data[int'(gnt_q)*DW +: DW] : '0;
        bus.gnt_id     = gnt_q;
        bus.busy       = in_burst;
    end

    // Next-state: grant in IDLE, count accepted words in BURST, leave on last word, full count or request drop.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid && !bus.fifo_full) begin
                    state_d = BURST;
                    gnt_d   = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (!bus.req[gnt_q]) begin
                    state_d = IDLE;
                end else if (accept) begin
                    cnt_d = cnt_inc;
                    if (bus.req_last[gnt_q] || (cnt_inc == CW'(BURST_MAX))) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset points last_gnt at the top requester so requester 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter DW, default 32, SHALL set the data width.
REQ-003 Parameter BURST_MAX, default 4, SHALL set the maximum words per grant (1..16).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 req  input  N_REQ  SHALL carry per-requester "word available" flags.
REQ-007 req_data  input  N_REQ*DW  SHALL carry the packed words; requester i occupies bits [i*DW +: DW].
REQ-008 req_last  input  N_REQ  SHALL mark the current word as the requester's last word of its burst.
REQ-009 ack  output  N_REQ  SHALL be one-hot or zero and pulse for each word accepted.
REQ-010 fifo_we  output  1  SHALL be the write enable to the downstream sync FIFO.
REQ-011 fifo_din  output  DW  SHALL be the write data to the downstream FIFO.
REQ-012 fifo_full  input  1  SHALL be the downstream FIFO full flag.
REQ-013 gnt_id  output  clog2(N_REQ)  SHALL identify the current owner; it is valid while busy=1.
REQ-014 busy  output  1  SHALL be high while in BURST state.

Function
REQ-015 The FSM SHALL have two states: IDLE and BURST.
REQ-016 In IDLE with any req high and fifo_full=0, the FSM SHALL select the first requester with req high, searching round-robin from last_gnt+1 modulo N_REQ; next cycle it SHALL enter BURST with gnt_id set to that requester, burst count 0, and last_gnt updated to it.
REQ-017 In IDLE, ack SHALL be 0 and fifo_we SHALL be 0; no word SHALL be accepted.
REQ-018 In BURST, accept SHALL equal req[gnt_id] AND NOT fifo_full, combinationally.
REQ-019 fifo_we SHALL equal accept, ack[gnt_id] SHALL equal accept, and fifo_din SHALL equal the owner's req_data slice (zero-latency datapath).
REQ-020 Each accept SHALL increment the burst count; the count width SHALL be clog2(BURST_MAX+1).
REQ-021 The burst SHALL end, with a return to IDLE next cycle, on any of the following:
- accept with req_last[gnt_id]=1;
- accept that brings the count to BURST_MAX;
- req[gnt_id]=0.
REQ-022 fifo_full=1 in BURST SHALL stall without ending the burst; the owner and count SHALL hold.
REQ-023 Every grant SHALL be followed by one IDLE arbitration cycle, so a single requester achieves at most BURST_MAX words per BURST_MAX+1 cycles.
REQ-024 Requests from non-owners during BURST SHALL be ignored and never acked.
REQ-025 When the only requester is last_gnt, it SHALL be re-granted (no starvation of a lone requester).

Reset
REQ-026 On rst=0, the block SHALL asynchronously force state=IDLE, gnt_id=0, count=0, and last_gnt=N_REQ-1, so requester 0 wins first.
REQ-027 During and immediately after reset, ack=0, fifo_we=0, fifo_din=0 and busy=0.
REQ-028 Reset asserted mid-burst SHALL abort the burst; no partial state SHALL survive.

Structure
REQ-029 Package fifo_arb_pkg SHALL hold the FSM state enum (IDLE, BURST) and the default values of N_REQ, DW and BURST_MAX.
REQ-030 A combinational sub-module rr_picker SHALL take (req, last_gnt) and return (valid, idx); it is the only sub-module.

Verification
REQ-031 After reset, req=4'b1111 held and fifo_full=0 -> grants in order 0,1,2,3,0, each BURST of 4 words followed by 1 IDLE cycle.
REQ-032 req=4'b0100 with req_last asserted on the 2nd word -> exactly 2 acks to requester 2, fifo_din equal to the requester-2 words, then busy=0.
REQ-033 Requester 1 in BURST with fifo_full raised for 3 cycles after the 1st word -> no ack or fifo_we during the stall; words 2..4 follow afterward; gnt_id stays 1.
REQ-034 Requester 3 drops req after 1 word -> burst ends, IDLE next cycle; a pending requester 0 is granted next.
REQ-035 rst pulsed low mid-burst on requester 2 -> immediate fifo_we=0 and busy=0; after release with req=4'b0101, requester 0 is granted first.
REQ-036 Only requester 0 requests continuously -> re-granted every 5 cycles; 4 words per grant; zero acks to other requesters.
